// File: rtl/regfile_pkg.sv
// Shared constants, types and address-qualification helper for the
// multiport register file and the decode/writeback stages that talk to it.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  localparam logic [DEFAULT_ADDR_W-1:0] ZERO_ADDR = '0;

  typedef logic [DEFAULT_ADDR_W-1:0] regfile_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] regfile_word_t;

  // True when an address names real, writable storage: inside the array and
  // not the hard-wired zero register.
  function automatic logic regfile_addr_ok(input int unsigned addr,
                                           input int unsigned num_regs,
                                           input bit          zero_reg);
    return (addr < num_regs) && !(zero_reg && addr == int'(ZERO_ADDR));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array/busy lookup with optional same-cycle
// forwarding from the write ports (highest write port wins).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        mem [NUM_REGS],
  input  logic [NUM_REGS-1:0]      busy,
  input  logic [NUM_WR-1:0]        wr_ok,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  always_comb begin
    // NOTE: combinational outputs get a default before any conditional
    // assignment, otherwise synthesis infers a latch.
    rd_data = '0;
    rd_busy = 1'b0;
    if (regfile_addr_ok(32'(addr), NUM_REGS, ZERO_REG != 0)) begin
      rd_data = mem[addr];
      rd_busy = busy[addr];
    end
    // wr_ok already excludes dropped writes, so forwarding never resurrects
    // the zero register or an out-of-range address. Later ports override.
    if (BYPASS != 0) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
          rd_data = wr_data[w*DATA_W +: DATA_W];
          rd_busy = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multiport register file with optional write-to-read bypass
// and a per-register busy scoreboard (claim at decode, release at writeback).
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] busy_rd;
  logic [NUM_WR-1:0]   wr_ok;
  logic                claim_ok;

  // Qualified strobes: reset and dropped addresses are filtered once here so
  // storage, scoreboard and bypass all agree on what a write is.
  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_ok[w] = wr_en[w] && !rst &&
                 regfile_addr_ok(32'(wr_addr[w*ADDR_W +: ADDR_W]), NUM_REGS, ZERO_REG != 0);
    end
  end

  assign claim_ok = claim_en && !rst &&
                    regfile_addr_ok(32'(claim_addr), NUM_REGS, ZERO_REG != 0);

  // Release first, then claim, so a same-cycle claim marks the new producer.
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_ok[w]) busy_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (claim_ok) busy_next[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is flop-based (many ports), so clearing every entry
      // on reset is cheap and gives deterministic reads after reset.
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments in port order; the last (highest)
      // port's assignment to a shared address is the one that sticks.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
      busy <= busy_next;
    end
  end

  // Scoreboard is hidden while reset is held.
  assign busy_rd = rst ? '0 : busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .mem    (mem),
      .busy   (busy_rd),
      .wr_ok  (wr_ok),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(rd_data[p*DATA_W +: DATA_W]),
      .rd_busy(rd_busy[p])
    );
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed and randomised checks of multiport_regfile across three
// configurations, with expected values queued on drive and popped on sample.
module tb_multiport_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: 2R/2W, bypass, zero register
  logic [9:0]  a_rd_addr;  logic [63:0] a_rd_data;  logic [1:0] a_rd_busy;
  logic [1:0]  a_wr_en;    logic [9:0]  a_wr_addr;  logic [63:0] a_wr_data;
  logic        a_claim_en; logic [4:0]  a_claim_addr;
  // B: 2R/1W, no bypass, ordinary register 0
  logic [9:0]  b_rd_addr;  logic [63:0] b_rd_data;  logic [1:0] b_rd_busy;
  logic [0:0]  b_wr_en;    logic [4:0]  b_wr_addr;  logic [31:0] b_wr_data;
  logic        b_claim_en; logic [4:0]  b_claim_addr;
  // C: 64-bit, 24 registers, 4R/2W
  logic [19:0]  c_rd_addr;  logic [255:0] c_rd_data; logic [3:0] c_rd_busy;
  logic [1:0]   c_wr_en;    logic [9:0]   c_wr_addr; logic [127:0] c_wr_data;
  logic         c_claim_en; logic [4:0]   c_claim_addr;

  multiport_regfile #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
                      .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .claim_en(a_claim_en), .claim_addr(a_claim_addr));

  multiport_regfile #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1),
                      .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .claim_en(b_claim_en), .claim_addr(b_claim_addr));

  multiport_regfile #(.DATA_W(64), .NUM_REGS(24), .NUM_RD(4), .NUM_WR(2),
                      .BYPASS(1), .ZERO_REG(1)) u_c (
    .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .claim_en(c_claim_en), .claim_addr(c_claim_addr));

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  // Reference model for configuration C
  logic [63:0] m_mem [24];
  logic [23:0] m_busy;
  logic [1:0]  r_en;
  logic [4:0]  r_wa [2];
  logic [63:0] r_wd [2];
  logic        r_cen;
  logic [4:0]  r_ca;
  logic [4:0]  r_ra;
  logic [63:0] e_data;
  logic        e_busy;

  task automatic push(input string tag, input logic [63:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop(input logic [63:0] obs);
    sb_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed=%h with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    a_wr_en = '0; a_claim_en = 1'b0;
    b_wr_en = '0; b_claim_en = 1'b0;
    c_wr_en = '0; c_claim_en = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic a_write(input int port, input logic [4:0] ad, input logic [31:0] d);
    a_wr_en[port] = 1'b1;
    a_wr_addr[port*5 +: 5]   = ad;
    a_wr_data[port*32 +: 32] = d;
  endtask

  task automatic b_write(input logic [4:0] ad, input logic [31:0] d);
    b_wr_en   = 1'b1;
    b_wr_addr = ad;
    b_wr_data = d;
  endtask

  function automatic logic c_ok(input logic [4:0] ad);
    return (ad < 5'd24) && (ad != 5'd0);
  endfunction

  initial begin
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_claim_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_claim_addr = '0;
    c_rd_addr = '0; c_wr_addr = '0; c_wr_data = '0; c_claim_addr = '0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    step();
    rst = 1'b0;

    // Post-reset state
    a_rd_addr = {5'd5, 5'd0};
    push("rst_p0", 64'h0); push("rst_p1", 64'h0); push("rst_busy", 64'h0);
    #1;
    pop(64'(a_rd_data[31:0])); pop(64'(a_rd_data[63:32])); pop(64'(a_rd_busy));

    // Fill r5, then reset with a write and claim pending in the reset cycle
    step(); a_write(0, 5'd5, 32'hDEADBEEF); b_write(5'd5, 32'hDEADBEEF);
    step(); a_rd_addr = {5'd6, 5'd5}; b_rd_addr = {5'd6, 5'd5};
    push("fill_a", 64'hDEADBEEF); push("fill_b", 64'hDEADBEEF);
    #1; pop(64'(a_rd_data[31:0])); pop(64'(b_rd_data[31:0]));

    step(); rst = 1'b1;
    a_write(0, 5'd6, 32'h77); a_claim_en = 1'b1; a_claim_addr = 5'd5;
    b_write(5'd6, 32'h77);
    push("rst_shows_array", 64'hDEADBEEF); push("rst_no_bypass", 64'h0); push("rst_busy_low", 64'h0);
    #1; pop(64'(a_rd_data[31:0])); pop(64'(a_rd_data[63:32])); pop(64'(a_rd_busy));

    step(); rst = 1'b0;
    push("rst_clr_a", 64'h0); push("rst_wr_dropped", 64'h0);
    push("rst_claim_dropped", 64'h0); push("rst_clr_b", 64'h0); push("rst_wr_dropped_b", 64'h0);
    #1; pop(64'(a_rd_data[31:0])); pop(64'(a_rd_data[63:32])); pop(64'(a_rd_busy));
    pop(64'(b_rd_data[31:0])); pop(64'(b_rd_data[63:32]));

    // Bypass vs. no bypass
    step(); a_write(0, 5'd7, 32'h1234); b_write(5'd7, 32'h1234);
    a_rd_addr = {5'd7, 5'd0}; b_rd_addr = {5'd7, 5'd0};
    push("byp_same", 64'h1234); push("nobyp_same", 64'h0);
    #1; pop(64'(a_rd_data[63:32])); pop(64'(b_rd_data[63:32]));
    step();
    push("byp_next", 64'h1234); push("nobyp_next", 64'h1234);
    #1; pop(64'(a_rd_data[63:32])); pop(64'(b_rd_data[63:32]));

    // Zero register: hard-wired in A, ordinary in B
    step(); a_write(0, 5'd0, 32'hFFFFFFFF); a_claim_en = 1'b1; a_claim_addr = 5'd0;
    b_write(5'd0, 32'hFFFFFFFF); b_claim_en = 1'b1; b_claim_addr = 5'd0;
    push("zero_a", 64'h0); push("zero_a_busy", 64'h0); push("zero_b_same", 64'h0);
    #1; pop(64'(a_rd_data[31:0])); pop(64'(a_rd_busy[0])); pop(64'(b_rd_data[31:0]));
    step();
    push("zero_a_next", 64'h0); push("zero_a_busy_next", 64'h0);
    push("zero_b_next", 64'hFFFFFFFF); push("zero_b_busy_next", 64'h1);
    #1; pop(64'(a_rd_data[31:0])); pop(64'(a_rd_busy[0]));
    pop(64'(b_rd_data[31:0])); pop(64'(b_rd_busy[0]));

    // Two write ports on the same register
    step(); a_write(0, 5'd3, 32'hA); a_write(1, 5'd3, 32'hB); a_rd_addr = {5'd3, 5'd0};
    push("conflict_bypass", 64'hB);
    #1; pop(64'(a_rd_data[63:32]));
    step();
    push("conflict_reg", 64'hB);
    #1; pop(64'(a_rd_data[63:32]));

    // Scoreboard: claim, release, claim+release
    step(); a_rd_addr = {5'd3, 5'd9}; b_rd_addr = {5'd7, 5'd9};
    a_claim_en = 1'b1; a_claim_addr = 5'd9; b_claim_en = 1'b1; b_claim_addr = 5'd9;
    push("claim_a_same", 64'h0); push("claim_b_same", 64'h0);
    #1; pop(64'(a_rd_busy[0])); pop(64'(b_rd_busy[0]));
    step();
    push("claim_a_next", 64'h1); push("claim_b_next", 64'h1);
    #1; pop(64'(a_rd_busy[0])); pop(64'(b_rd_busy[0]));
    step(); a_write(0, 5'd9, 32'h55); b_write(5'd9, 32'h55);
    push("release_a_same", 64'h0); push("release_a_data", 64'h55); push("release_b_same", 64'h1);
    #1; pop(64'(a_rd_busy[0])); pop(64'(a_rd_data[31:0])); pop(64'(b_rd_busy[0]));
    step();
    push("release_a_next", 64'h0); push("release_b_next", 64'h0); push("release_b_data", 64'h55);
    #1; pop(64'(a_rd_busy[0])); pop(64'(b_rd_busy[0])); pop(64'(b_rd_data[31:0]));
    step(); a_write(0, 5'd9, 32'h55); a_claim_en = 1'b1; a_claim_addr = 5'd9;
    push("claim_wr_same_busy", 64'h0);
    #1; pop(64'(a_rd_busy[0]));
    step();
    push("claim_wr_data", 64'h55); push("claim_wr_busy", 64'h1);
    #1; pop(64'(a_rd_data[31:0])); pop(64'(a_rd_busy[0]));

    // Config C: out-of-range address 30
    step(); c_wr_en[0] = 1'b1; c_wr_addr[4:0] = 5'd30; c_wr_data[63:0] = 64'h0123456789ABCDEF;
    c_rd_addr = {4{5'd30}};
    push("oor_same", 64'h0);
    #1; pop(c_rd_data[63:0]);
    step();
    push("oor_next", 64'h0); push("oor_busy", 64'h0);
    #1; pop(c_rd_data[63:0]); pop(64'(c_rd_busy));

    // Config C: randomised traffic against the reference model
    for (int r = 0; r < 24; r++) m_mem[r] = '0;
    m_busy = '0;
    for (int it = 0; it < 60; it++) begin
      step();
      for (int w = 0; w < 2; w++) begin
        r_en[w] = 1'($urandom_range(0, 1));
        r_wa[w] = 5'($urandom_range(0, 31));
        r_wd[w] = {$urandom, $urandom};
        c_wr_en[w]           = r_en[w];
        c_wr_addr[w*5 +: 5]   = r_wa[w];
        c_wr_data[w*64 +: 64] = r_wd[w];
      end
      r_cen = 1'($urandom_range(0, 1));
      r_ca  = 5'($urandom_range(0, 31));
      c_claim_en = r_cen; c_claim_addr = r_ca;
      // Ports 2/3 track the write addresses so bypass and conflicts get hit.
      c_rd_addr = {r_wa[1], r_wa[0], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      for (int p = 0; p < 4; p++) begin
        r_ra = c_rd_addr[p*5 +: 5];
        e_data = '0;
        e_busy = 1'b0;
        if (c_ok(r_ra)) begin
          e_data = m_mem[r_ra];
          e_busy = m_busy[r_ra];
        end
        for (int w = 0; w < 2; w++) begin
          if (r_en[w] && c_ok(r_wa[w]) && r_wa[w] == r_ra) begin
            e_data = r_wd[w];
            e_busy = 1'b0;
          end
        end
        push($sformatf("rand%0d_data%0d", it, p), e_data);
        push($sformatf("rand%0d_busy%0d", it, p), 64'(e_busy));
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        pop(c_rd_data[p*64 +: 64]);
        pop(64'(c_rd_busy[p]));
      end
      for (int w = 0; w < 2; w++) begin
        if (r_en[w] && c_ok(r_wa[w])) begin
          m_mem[r_wa[w]]  = r_wd[w];
          m_busy[r_wa[w]] = 1'b0;
        end
      end
      if (r_cen && c_ok(r_ca)) m_busy[r_ca] = 1'b1;
    end

    step();
    if (sb_q.size() != 0) begin
      n_err++;
      $error("FAIL sb_leftover: observed=%0d entries expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
